// File: rtl/nn_layer_pkg.sv
// Shared types and helpers for the dense-layer MAC sequencer.
//   state_t  : sequencer FSM states
//   *_DEF    : default fixed-point format
//   ACT_*    : activation selectors
//   idx_w()  : index width for n items, never narrower than one bit
//   sat_dw() : clamp a wide signed value into a dw-bit signed range
package nn_layer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ACC,
      S_BIAS,
      S_OUT,
      S_DONE
   } state_t;

   localparam int DATA_W_DEF   = 8;
   localparam int FRAC_DEF     = 4;
   localparam int ACT_IDENTITY = 0;
   localparam int ACT_RELU     = 1;

   // Working width for the bias add and saturation; must exceed ACC_W.
   localparam int SAT_W = 32;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                      input int                      dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] r;
      hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
      lo = ~hi;
      r  = v;
      if (v > hi) r = hi;
      if (v < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/nn_layer_mac_sequencer_mac.sv
// nn_mac_unit: signed multiply, arithmetic shift by FRAC, and a wrapping
// accumulator with synchronous clear (priority) and enable.
//   clk, rst : clock, synchronous active-high reset
//   clr, en  : clear accumulator / add current product
//   a, b     : signed operands (DATA_W)
//   acc      : accumulator value (ACC_W, signed)
module nn_mac_unit #(
   parameter int DATA_W = 8,
   parameter int FRAC   = 4,
   parameter int ACC_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic        [DATA_W-1:0] a,
   input  logic        [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [2*DATA_W-1:0] prod_sh;
   logic signed [ACC_W-1:0]    acc_d;
   logic signed [ACC_W-1:0]    acc_q;

   assign prod    = $signed(a) * $signed(b);
   assign prod_sh = prod >>> FRAC;

   always_comb begin
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + ACC_W'(prod_sh);
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/nn_layer_mac_sequencer.sv
// nn_layer_mac_sequencer: runs one shared MAC over every neuron of a dense
// layer, generating input-select / weight / bias addresses and emitting one
// activated, saturated result per neuron. Index ports are at least 1 bit wide.
//   clk, rst            : clock, synchronous active-high reset
//   req / ack           : four-phase start/done handshake
//   in_sel / in_data    : layer input index and its combinational value
//   w_addr / w_data     : weight ROM (j*N_IN+k), data one cycle later
//   b_addr / b_data     : bias ROM (j), data one cycle later
//   out_idx/out_data/out_valid : per-neuron result strobe
//
// state  | meaning
// IDLE   | wait for req with ack low; acc, j, k held at zero
// ADDR   | present w_addr/in_sel for (j,k)
// ACC    | accumulate in_data*w_data; advance k or go to BIAS
// BIAS   | present b_addr for neuron j
// OUT    | add bias, activate, saturate, strobe; advance j or go to DONE
// DONE   | ack high until req falls
module nn_layer_mac_sequencer
   import nn_layer_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int N_OUT  = 1,
   parameter int DATA_W = DATA_W_DEF,
   parameter int FRAC   = FRAC_DEF,
   parameter int ACC_W  = 16,
   parameter int ACT    = ACT_RELU
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req,
   output logic                             ack,
   output logic [idx_w(N_IN)-1:0]           in_sel,
   input  logic [DATA_W-1:0]                in_data,
   output logic [idx_w(N_IN*N_OUT)-1:0]     w_addr,
   input  logic [DATA_W-1:0]                w_data,
   output logic [idx_w(N_OUT)-1:0]          b_addr,
   input  logic [DATA_W-1:0]                b_data,
   output logic [idx_w(N_OUT)-1:0]          out_idx,
   output logic [DATA_W-1:0]                out_data,
   output logic                             out_valid
);

   localparam int SEL_W = idx_w(N_IN);
   localparam int WA_W  = idx_w(N_IN*N_OUT);
   localparam int IDX_W = idx_w(N_OUT);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   k_q, k_d;
   logic [IDX_W-1:0]   j_q, j_d;
   logic               ack_q, ack_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;

   logic                    acc_clr;
   logic                    acc_en;
   logic signed [ACC_W-1:0] acc;
   logic signed [SAT_W-1:0] sum_s;
   logic signed [SAT_W-1:0] act_s;

   nn_mac_unit #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .en  (acc_en),
      .a   (in_data),
      .b   (w_data),
      .acc (acc)
   );

   // Bias add is done wide so only the final result saturates.
   always_comb begin
      sum_s = SAT_W'(acc) + SAT_W'($signed(b_data));
      act_s = sum_s;
      if (ACT == ACT_RELU && sum_s[SAT_W-1]) act_s = '0;
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      j_d         = j_q;
      ack_d       = ack_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      acc_clr     = 1'b0;
      acc_en      = 1'b0;
      case (state_q)
         S_IDLE: begin
            acc_clr = 1'b1;
            k_d     = '0;
            j_d     = '0;
            if (req && !ack_q) state_d = S_ADDR;
         end
         S_ADDR: state_d = S_ACC;
         S_ACC: begin
            acc_en = 1'b1;
            if (k_q == SEL_W'(N_IN - 1)) begin
               state_d = S_BIAS;
            end else begin
               k_d     = k_q + SEL_W'(1);
               state_d = S_ADDR;
            end
         end
         S_BIAS: state_d = S_OUT;
         S_OUT: begin
            out_valid_d = 1'b1;
            out_data_d  = DATA_W'(sat_dw(act_s, DATA_W));
            out_idx_d   = j_q;
            acc_clr     = 1'b1;
            k_d         = '0;
            if (j_q == IDX_W'(N_OUT - 1)) begin
               state_d = S_DONE;
               ack_d   = 1'b1;
            end else begin
               j_d     = j_q + IDX_W'(1);
               state_d = S_ADDR;
            end
         end
         S_DONE: begin
            if (!req) begin
               state_d = S_IDLE;
               ack_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         j_q         <= '0;
         ack_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         j_q         <= j_d;
         ack_q       <= ack_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign in_sel    = k_q;
   assign w_addr    = WA_W'(j_q) * WA_W'(N_IN) + WA_W'(k_q);
   assign b_addr    = j_q;
   assign ack       = ack_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;

endmodule
